// File: rtl/decim_filt_pkg.sv
// decim_filt_pkg: shared FSM state type and arithmetic helpers for the decimation filter.
package decim_filt_pkg;

   typedef enum logic [1:0] {IDLE, MAC, OUT} decim_state_t;

   // Widest accumulator needed so summing NUM_TAPS full-scale products cannot overflow
   function automatic int acc_width(input int data_width, input int coeff_width, input int num_taps);
      return data_width + coeff_width + $clog2(num_taps + 1);
   endfunction

   // Floor-rounding arithmetic right shift followed by clamp to a dw-bit signed range
   function automatic logic signed [63:0] sat_shift(input logic signed [63:0] a, input int sh, input int dw);
      logic signed [63:0] s, hi, lo;
      s  = a >>> sh;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (dw - 1));
      return s > hi ? hi : s < lo ? lo : s;
   endfunction

endpackage

// File: rtl/decim_filt_if.sv
// decim_filt_if: sample stream, coefficient set and status bundle of decim_filt.
interface decim_filt_if #(
   parameter int DATA_WIDTH      = 5,
   parameter int TAP_COEFF_WIDTH = 5,
   parameter int NUM_TAPS        = 2
);
   logic                              in_valid;
   logic signed [DATA_WIDTH-1:0]      in;
   logic signed [TAP_COEFF_WIDTH-1:0] tap_coeffs [NUM_TAPS];
   logic signed [DATA_WIDTH-1:0]      out;
   logic                              out_valid;
   logic                              busy;
   logic                              overrun;

   modport master (output in_valid, in, tap_coeffs, input out, out_valid, busy, overrun);
   modport slave  (input in_valid, in, tap_coeffs, output out, out_valid, busy, overrun);
endinterface

// File: rtl/decim_filt_mac.sv
// decim_filt_mac: single signed multiplier feeding a clearable accumulator.
module decim_filt_mac #(
   parameter int DW = 5,
   parameter int CW = 5,
   parameter int AW = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 en,
   input  logic signed [DW-1:0] a,
   input  logic signed [CW-1:0] b,
   output logic signed [AW-1:0] acc
);
   logic signed [DW+CW-1:0] prod;

   assign prod = a * b;

   always_ff @(posedge clk) begin
      if (!rst_n || clr)
         acc <= '0;
      else if (en)
         acc <= acc + {{(AW-DW-CW){prod[DW+CW-1]}}, prod};
   end
endmodule

// File: rtl/decim_filt.sv
// decim_filt: FIR decimator; every DECIM_FACTOR-th accepted sample launches a
// time-shared MAC pass over a snapshot of the newest NUM_TAPS samples.
module decim_filt
   import decim_filt_pkg::*;
#(
   parameter int DATA_WIDTH      = 5,
   parameter int TAP_COEFF_WIDTH = 5,
   parameter int NUM_TAPS        = 2,
   parameter int DECIM_FACTOR    = 4
) (
   input logic         clk,
   input logic         rst_n,
   decim_filt_if.slave bus
);
   localparam int AW = acc_width(DATA_WIDTH, TAP_COEFF_WIDTH, NUM_TAPS);
   localparam int IW = NUM_TAPS > 1 ? $clog2(NUM_TAPS) : 1;
   localparam int PW = DECIM_FACTOR > 1 ? $clog2(DECIM_FACTOR) : 1;

   decim_state_t                 state, state_nx;
   logic signed [DATA_WIDTH-1:0] dl  [NUM_TAPS];
   logic signed [DATA_WIDTH-1:0] win [NUM_TAPS];
   logic [IW-1:0]                idx;
   logic [PW-1:0]                ph;
   logic signed [AW-1:0]         acc;
   logic                         trig, last, start, mac_en;

   assign trig = bus.in_valid && ph == PW'(DECIM_FACTOR - 1);
   assign last = idx == IW'(NUM_TAPS - 1);

   always_ff @(posedge clk)
      state <= !rst_n ? IDLE : state_nx;

   // OUT can hand straight over to a new pass, so a trigger there is not an overrun
   always_comb
      state_nx = state == MAC ? (last ? OUT : MAC) : (trig ? MAC : IDLE);

   always_comb begin
      start    = trig && state != MAC;
      mac_en   = state == MAC;
      bus.busy = state != IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dl            <= '{default: '0};
         win           <= '{default: '0};
         idx           <= '0;
         ph            <= '0;
         bus.out       <= '0;
         bus.out_valid <= 1'b0;
         bus.overrun   <= 1'b0;
      end else begin
         if (bus.in_valid) begin
            dl[0] <= bus.in;
            for (int i = 1; i < NUM_TAPS; i++) dl[i] <= dl[i-1];
            ph <= ph == PW'(DECIM_FACTOR - 1) ? '0 : ph + 1'b1;
         end
         if (start) begin
            win[0] <= bus.in;
            for (int i = 1; i < NUM_TAPS; i++) win[i] <= dl[i-1];
         end
         idx           <= start ? '0 : mac_en ? idx + 1'b1 : idx;
         bus.out_valid <= state == OUT;
         if (state == OUT)
            bus.out <= DATA_WIDTH'(sat_shift(64'(acc), TAP_COEFF_WIDTH - 1, DATA_WIDTH));
         if (trig && state == MAC)
            bus.overrun <= 1'b1;
      end
   end

   decim_filt_mac #(.DW(DATA_WIDTH), .CW(TAP_COEFF_WIDTH), .AW(AW)) u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start),
      .en    (mac_en),
      .a     (win[idx]),
      .b     (bus.tap_coeffs[idx]),
      .acc   (acc)
   );
endmodule

// File: tb/tb_decim_filt.sv
// tb_decim_filt: directed checks of decim_filt with 2 taps at M=4 (dut a) and M=2 (dut b).
module tb_decim_filt;
   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc, pulses, first_p, second_p, seen;

   always #5 clk = ~clk;

   decim_filt_if #(.DATA_WIDTH(5), .TAP_COEFF_WIDTH(5), .NUM_TAPS(2)) ia ();
   decim_filt_if #(.DATA_WIDTH(5), .TAP_COEFF_WIDTH(5), .NUM_TAPS(2)) ib ();

   decim_filt #(.DATA_WIDTH(5), .TAP_COEFF_WIDTH(5), .NUM_TAPS(2), .DECIM_FACTOR(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ia.slave));
   decim_filt #(.DATA_WIDTH(5), .TAP_COEFF_WIDTH(5), .NUM_TAPS(2), .DECIM_FACTOR(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ib.slave));

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_pulse(output int c);
      c = 0;
      do begin
         step();
         c++;
      end while (!ia.out_valid && c < 50);
      chk("pulse_seen", ia.out_valid, 1);
   endtask

   initial begin
      rst_n = 1'b0;
      ia.in_valid = 1'b0; ia.in = '0; ia.tap_coeffs[0] = 5'sd15; ia.tap_coeffs[1] = 5'sd15;
      ib.in_valid = 1'b0; ib.in = '0; ib.tap_coeffs[0] = 5'sd15; ib.tap_coeffs[1] = 5'sd15;
      step(); step();
      chk("rst_out", ia.out, 0);
      chk("rst_out_valid", ia.out_valid, 0);
      chk("rst_busy", ia.busy, 0);
      chk("rst_overrun", ia.overrun, 0);
      rst_n = 1'b1;

      // constant 3: 2*3*15=90, 90>>>4=5, pulse three edges after the 4th valid edge
      ia.in = 5'sd3; ia.in_valid = 1'b1;
      repeat (3) step();
      chk("no_trig_before_4th", ia.busy, 0);
      step();
      chk("busy_after_trig", ia.busy, 1);
      step(); step();
      chk("no_pulse_early", ia.out_valid, 0);
      step();
      chk("c3_pulse", ia.out_valid, 1);
      chk("c3_out", ia.out, 5);
      step();
      chk("pulse_one_cycle", ia.out_valid, 0);
      chk("out_held", ia.out, 5);
      wait_pulse(cyc);
      chk("c3_period", cyc, 3);
      chk("c3_out_again", ia.out, 5);

      // 15: mixed window {15,3} gives 270>>>4=16 -> 15, pure 450>>>4=28 -> 15
      ia.in = 5'sd15;
      wait_pulse(cyc);
      chk("mix15_out", ia.out, 15);
      wait_pulse(cyc);
      chk("sat_pos_out", ia.out, 15);
      chk("period4", cyc, 4);

      // -16: mixed {-16,15} gives -15>>>4=-1, pure -480>>>4=-30 -> -16
      ia.in = -5'sd16;
      wait_pulse(cyc);
      chk("mix_neg_floor", ia.out, -1);
      wait_pulse(cyc);
      chk("sat_neg_out", ia.out, -16);

      // -1: mixed {-1,-16} gives -255>>>4=-16, pure -30>>>4=-2
      ia.in = -5'sd1;
      wait_pulse(cyc);
      chk("mix_m1_out", ia.out, -16);
      wait_pulse(cyc);
      chk("floor_out", ia.out, -2);
      step();
      chk("floor_out_held", ia.out, -2);
      chk("overrun_a_clear", ia.overrun, 0);

      // gapped input: valid on even cycles, triggers on iterations 6 and 14
      rst_n = 1'b0; ia.in_valid = 1'b0;
      step();
      rst_n = 1'b1; ia.in = 5'sd3;
      pulses = 0; first_p = -1; second_p = -1;
      for (int c = 0; c < 20; c++) begin
         ia.in_valid = (c % 2) == 0;
         step();
         if (ia.out_valid) begin
            pulses++;
            if (first_p < 0) first_p = c; else second_p = c;
         end
      end
      chk("gap_pulses", pulses, 2);
      chk("gap_first", first_p, 9);
      chk("gap_second", second_p, 17);
      chk("gap_out", ia.out, 5);

      // reset one cycle after a trigger, with in_valid held high during reset
      rst_n = 1'b0; ia.in_valid = 1'b0;
      step();
      rst_n = 1'b1; ia.in_valid = 1'b1; ia.in = 5'sd3;
      repeat (4) step();
      chk("mid_trig_busy", ia.busy, 1);
      rst_n = 1'b0;
      step();
      chk("mid_rst_busy", ia.busy, 0);
      chk("mid_rst_out", ia.out, 0);
      chk("mid_rst_valid", ia.out_valid, 0);
      chk("mid_rst_overrun", ia.overrun, 0);
      step();
      rst_n = 1'b1; ia.in_valid = 1'b0;
      seen = 0;
      repeat (5) begin
         step();
         if (ia.out_valid) seen++;
      end
      chk("mid_rst_no_pulse", seen, 0);
      ia.in_valid = 1'b1;
      repeat (3) step();
      chk("ph_cleared_by_rst", ia.busy, 0);
      step();
      chk("ph_trig_4th", ia.busy, 1);
      ia.in_valid = 1'b0;

      // overrun at M=2: trigger at edge 2 accepted, edge 4 dropped mid-MAC
      ib.in = 5'sd3; ib.in_valid = 1'b1;
      pulses = 0;
      for (int e = 1; e <= 20; e++) begin
         step();
         if (ib.out_valid) pulses++;
         if (e == 3) begin
            chk("ovr_busy", ib.busy, 1);
            chk("ovr_before", ib.overrun, 0);
         end
         if (e == 4) chk("ovr_rise", ib.overrun, 1);
         if (e == 5) begin
            chk("ovr_b_pulse", ib.out_valid, 1);
            chk("ovr_b_out", ib.out, 5);
         end
      end
      chk("ovr_pulses", pulses, 4);
      chk("ovr_sticky", ib.overrun, 1);
      chk("ovr_a_unaffected", ia.overrun, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
